capture_ctrl_n: RTL and testbench

Parametrised capture controller for the sample path between the RLE stage and sample memory. It generalises the arm/run/capture control to GRP channel groups and an AW-bit sample count. It adds group compaction, a ready/valid handshake on the memory write stream, overrun detection and optional auto-rearm. Configuration writes arrive from the command decoder; the memory write stream feeds the memory writer.

---
 rtl/capture_ctrl_n_if.sv | 29 ++
 rtl/capture_ctrl_n.sv | 197 +++++++++++++++++++
 tb/tb_capture_ctrl_n.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/capture_ctrl_n_if.sv
// -----------------------------------------------------------------------------
// capture_ctrl_n_if
// Sample-path bus for capture_ctrl_n. It carries two streams:
//   sti_valid / sti_data             incoming samples from the RLE stage
//   mwr_tdata / mwr_tvalid /
//   mwr_tready / mwr_tlast           ready/valid write stream to the memory writer
// modport master : the environment side (drives samples, provides tready)
// modport slave  : the capture controller side
// -----------------------------------------------------------------------------
interface capture_ctrl_n_if #(
    parameter int GRP = 4
) ();
    logic               sti_valid;
    logic [8*GRP-1:0]   sti_data;
    logic [8*GRP-1:0]   mwr_tdata;
    logic               mwr_tvalid;
    logic               mwr_tready;
    logic               mwr_tlast;

    modport master (
        output sti_valid, sti_data, mwr_tready,
        input  mwr_tdata, mwr_tvalid, mwr_tlast
    );

    modport slave (
        input  sti_valid, sti_data, mwr_tready,
        output mwr_tdata, mwr_tvalid, mwr_tlast
    );
endinterface

// File: rtl/capture_ctrl_n.sv
// -----------------------------------------------------------------------------
// capture_ctrl_n
// Capture controller between the RLE stage and sample memory. Arms on a pulse,
// writes pre-trigger samples, counts a programmable number of post-trigger
// samples after run, compacts disabled channel groups out of each sample and
// presents the result on a ready/valid stream with tlast on the final sample.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg_valid/addr/data config writes: 0=post count, 1=pre count,
//                       2=disabled-group mask, 3=control {tlast_on_trigger, auto_rearm}
//   arm, run, abort     control pulses (abort ends a capture immediately)
//   sif (slave)         sti_* sample input, mwr_* write stream output
//   indicator_arm/trg   registered state decodes
//   overrun             sticky: a sample was dropped because the output was full
//   done                one-cycle pulse at the end of each capture
//
// Build option: define RUN_HOLDOFF_EN to ignore run in ARMED until the
// pre-trigger count has reached the programmed pre-trigger window.
// -----------------------------------------------------------------------------
module capture_ctrl_n #(
    parameter int GRP = 4,
    parameter int AW  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_valid,
    input  logic [1:0]      cfg_addr,
    input  logic [31:0]     cfg_data,
    input  logic            arm,
    input  logic            run,
    input  logic            abort,
    capture_ctrl_n_if.slave sif,
    output logic            indicator_arm,
    output logic            indicator_trg,
    output logic            overrun,
    output logic            done
);
    localparam int DW = 8 * GRP;

    // S_WLAST waits for the tlast sample to be accepted before DONE.
    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_TRIG, S_WLAST, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   post_cfg_q, pre_cfg_q, post_eff;
    logic [GRP-1:0]  mask_q;
    logic [1:0]      ctrl_q;
    logic [AW-1:0]   pre_cnt_q, pre_cnt_d, post_cnt_q, post_cnt_d;
    logic [DW-1:0]   tdata_q, tdata_d;
    logic            tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic            overrun_q, overrun_d;
    logic            done_q, done_d, ind_arm_q, ind_arm_d, ind_trg_q, ind_trg_d;
    logic            mask_all, out_free, holdoff_ok, run_ok, in_smp;
    logic            accept, drop, wr, post_phase, last_smp;
    logic            unused_bits;

    // Pack enabled groups (mask bit 0) toward the LSB; upper bytes stay zero.
    function automatic logic [DW-1:0] compact(input logic [DW-1:0] d, input logic [GRP-1:0] m);
        logic [DW-1:0]  r;
        logic [GRP-1:0] ms;
        logic [7:0]     b;
        r = '0;
        for (int i = GRP - 1; i >= 0; i--) begin
            ms = m >> i;
            if (!ms[0]) begin
                b = 8'(d >> (8 * i));
                r = (r << 8) | DW'(b);
            end
        end
        return r;
    endfunction

`ifdef RUN_HOLDOFF_EN
    assign holdoff_ok = (pre_cnt_q >= pre_cfg_q);
`else
    assign holdoff_ok = 1'b1;
`endif
    // Upper cfg_data bits and, without holdoff, the pre-trigger state have no reader.
    assign unused_bits = ^{cfg_data, pre_cfg_q, pre_cnt_q};

    assign post_eff = (post_cfg_q == '0) ? AW'(1) : post_cfg_q;
    assign mask_all = &mask_q;
    assign out_free = !tvalid_q || sif.mwr_tready;

    always_comb begin
        run_ok     = (state_q == S_ARMED) && run && !abort && holdoff_ok;
        in_smp     = sif.sti_valid && !abort && (state_q == S_ARMED || state_q == S_TRIG);
        // With every group disabled nothing is written, so a sample can never be blocked.
        accept     = in_smp && (mask_all || out_free);
        drop       = in_smp && !accept;
        wr         = accept && !mask_all;
        post_phase = (state_q == S_TRIG) || run_ok;
        last_smp   = accept && post_phase && ((post_cnt_q + AW'(1)) == post_eff);

        pre_cnt_d  = pre_cnt_q;
        post_cnt_d = post_cnt_q;
        if (state_q == S_DONE || (state_q == S_IDLE && arm)) begin
            pre_cnt_d  = '0;
            post_cnt_d = '0;
        end else if (accept) begin
            if (post_phase)
                post_cnt_d = post_cnt_q + AW'(1);
            else if (pre_cnt_q != {AW{1'b1}})
                pre_cnt_d = pre_cnt_q + AW'(1);
        end

        tvalid_d = tvalid_q && !sif.mwr_tready;
        tlast_d  = tlast_q && !sif.mwr_tready;
        tdata_d  = tdata_q;
        if (wr) begin
            tvalid_d = 1'b1;
            tdata_d  = compact(sif.sti_data, mask_q);
            tlast_d  = last_smp || (run_ok && ctrl_q[1]);
        end

        overrun_d = overrun_q;
        if (state_q == S_IDLE && arm)
            overrun_d = 1'b0;
        else if (drop)
            overrun_d = 1'b1;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (arm) state_d = S_ARMED;
            S_ARMED, S_TRIG: begin
                if (abort)
                    state_d = S_DONE;
                else if (last_smp)
                    state_d = mask_all ? S_DONE : S_WLAST;
                else if (run_ok)
                    state_d = S_TRIG;
            end
            S_WLAST: if (tvalid_q && sif.mwr_tready) state_d = S_DONE;
            S_DONE:  state_d = ctrl_q[0] ? S_ARMED : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode, registered so the flags line up with the state they describe
    always_comb begin
        done_d    = (state_d == S_DONE);
        ind_arm_d = (state_d == S_ARMED);
        ind_trg_d = (state_d == S_TRIG) || (state_d == S_WLAST);
    end

    // State, configuration and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            post_cfg_q <= AW'(1);
            pre_cfg_q  <= '0;
            mask_q     <= '0;
            ctrl_q     <= '0;
            pre_cnt_q  <= '0;
            post_cnt_q <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            overrun_q  <= 1'b0;
            done_q     <= 1'b0;
            ind_arm_q  <= 1'b0;
            ind_trg_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            post_cnt_q <= post_cnt_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            overrun_q  <= overrun_d;
            done_q     <= done_d;
            ind_arm_q  <= ind_arm_d;
            ind_trg_q  <= ind_trg_d;
            if (cfg_valid) begin
                unique case (cfg_addr)
                    2'd0: post_cfg_q <= cfg_data[AW-1:0];
                    2'd1: pre_cfg_q  <= cfg_data[AW-1:0];
                    2'd2: mask_q     <= cfg_data[GRP-1:0];
                    2'd3: ctrl_q     <= cfg_data[1:0];
                    default: ;
                endcase
            end
        end
    end

    assign sif.mwr_tdata  = tdata_q;
    assign sif.mwr_tvalid = tvalid_q;
    assign sif.mwr_tlast  = tlast_q;
    assign indicator_arm  = ind_arm_q;
    assign indicator_trg  = ind_trg_q;
    assign overrun        = overrun_q;
    assign done           = done_q;

endmodule

// File: tb/tb_capture_ctrl_n.sv
module tb_capture_ctrl_n;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        arm, run, abort;
    logic        indicator_arm, indicator_trg, overrun, done;

    capture_ctrl_n_if #(.GRP(4)) sif ();

    capture_ctrl_n #(.GRP(4), .AW(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_valid     (cfg_valid),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .arm           (arm),
        .run           (run),
        .abort         (abort),
        .sif           (sif),
        .indicator_arm (indicator_arm),
        .indicator_trg (indicator_trg),
        .overrun       (overrun),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] din;
        logic [31:0] dout;
    } vec_t;

    exp_t sb[$];
    vec_t vt[7];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_done = 0;
    int   n_vld = 0;
    int   done_cyc = 0;
    int   tlast_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Write-stream monitor: pops the scoreboard on every handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sif.mwr_tvalid) n_vld++;
            if (sif.mwr_tvalid && sif.mwr_tready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", sif.mwr_tdata, 32'hDEADDEAD);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("wr_data", sif.mwr_tdata, e.data);
                    chk("wr_last", {31'd0, sif.mwr_tlast}, {31'd0, e.last});
                    if (e.last) tlast_cyc = cyc;
                end
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] a, input logic [31:0] d);
        cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic drv(input logic v, input logic [31:0] d, input logic r, input logic ab);
        sif.sti_valid = v; sif.sti_data = d; run = r; abort = ab;
        tick();
        sif.sti_valid = 1'b0; run = 1'b0; abort = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int base);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (n_done > base) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("done_pulse", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        int base;
        int vbase;

        // compaction vectors: mask bit set = group disabled
        vt[0] = '{4'b0000, 32'h44332211, 32'h44332211};
        vt[1] = '{4'b0101, 32'h44332211, 32'h00004422};
        vt[2] = '{4'b1010, 32'h44332211, 32'h00003311};
        vt[3] = '{4'b0001, 32'h44332211, 32'h00443322};
        vt[4] = '{4'b1110, 32'h44332211, 32'h00000011};
        vt[5] = '{4'b0111, 32'hA1B2C3D4, 32'h000000A1};
        vt[6] = '{4'b1000, 32'hA1B2C3D4, 32'h00B2C3D4};

        rst_n = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
        arm = 1'b0; run = 1'b0; abort = 1'b0;
        sif.sti_valid = 1'b0; sif.sti_data = '0; sif.mwr_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid",  {31'd0, sif.mwr_tvalid}, 32'd0);
        chk("rst_tlast",   {31'd0, sif.mwr_tlast}, 32'd0);
        chk("rst_tdata",   sif.mwr_tdata, 32'd0);
        chk("rst_ind_arm", {31'd0, indicator_arm}, 32'd0);
        chk("rst_ind_trg", {31'd0, indicator_trg}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_done",    {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_after_rst", {31'd0, indicator_arm}, 32'd0);

        // basic capture: 3 pre-trigger, trigger sample, 3 post-trigger
        cfg(2'd0, 32'd4);
        cfg(2'd2, 32'd0);
        cfg(2'd3, 32'd0);
        base = n_done;
        do_arm();
        chk("t1_ind_arm", {31'd0, indicator_arm}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            push(32'h10000000 + k, 1'b0);
            drv(1'b1, 32'h10000000 + k, 1'b0, 1'b0);
        end
        push(32'hA5A5A5A5, 1'b0);
        drv(1'b1, 32'hA5A5A5A5, 1'b1, 1'b0);
        chk("t1_ind_trg", {31'd0, indicator_trg}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            push(32'h20000000 + k, k == 2);
            drv(1'b1, 32'h20000000 + k, 1'b0, 1'b0);
        end
        wait_done(base);
        chk("t1_done_lat", done_cyc - tlast_cyc, 32'd1);
        tick();
        chk("t1_done_1cyc", {31'd0, done}, 32'd0);
        chk("t1_idle_arm", {31'd0, indicator_arm}, 32'd0);
        chk("t1_idle_trg", {31'd0, indicator_trg}, 32'd0);
        chk("t1_sb_empty", sb.size(), 32'd0);

        // compaction table, post=1 so the trigger sample is also the last
        cfg(2'd0, 32'd1);
        for (int i = 0; i < 7; i++) begin
            cfg(2'd2, {28'd0, vt[i].mask});
            base = n_done;
            do_arm();
            push(vt[i].dout, 1'b1);
            drv(1'b1, vt[i].din, 1'b1, 1'b0);
            wait_done(base);
            tick();
        end
        chk("t2_sb_empty", sb.size(), 32'd0);

        // all groups disabled: nothing written, capture still completes
        cfg(2'd2, 32'hF);
        cfg(2'd0, 32'd3);
        vbase = n_vld;
        base = n_done;
        do_arm();
        drv(1'b1, 32'h11111111, 1'b1, 1'b0);
        drv(1'b1, 32'h22222222, 1'b0, 1'b0);
        drv(1'b1, 32'h33333333, 1'b0, 1'b0);
        wait_done(base);
        tick();
        chk("t2_no_tvalid", n_vld - vbase, 32'd0);

        // backpressure: first sample held, next three dropped
        cfg(2'd2, 32'd0);
        cfg(2'd0, 32'd10);
        sif.mwr_tready = 1'b0;
        do_arm();
        drv(1'b1, 32'hCAFE0001, 1'b0, 1'b0);
        chk("t3_tvalid", {31'd0, sif.mwr_tvalid}, 32'd1);
        chk("t3_first", sif.mwr_tdata, 32'hCAFE0001);
        for (int k = 0; k < 3; k++) begin
            drv(1'b1, 32'hBAD00000 + k, 1'b0, 1'b0);
            chk("t3_hold", sif.mwr_tdata, 32'hCAFE0001);
        end
        chk("t3_overrun", {31'd0, overrun}, 32'd1);
        push(32'hCAFE0001, 1'b0);
        sif.mwr_tready = 1'b1;
        tick();
        base = n_done;
        drv(1'b0, 32'd0, 1'b0, 1'b1);
        wait_done(base);
        tick();
        chk("t3_sticky", {31'd0, overrun}, 32'd1);
        do_arm();
        chk("t3_arm_clears", {31'd0, overrun}, 32'd0);
        base = n_done;
        drv(1'b0, 32'd0, 1'b0, 1'b1);
        wait_done(base);
        tick();

        // abort two cycles after run
        cfg(2'd0, 32'd100);
        base = n_done;
        do_arm();
        push(32'hB0000001, 1'b0);
        drv(1'b1, 32'hB0000001, 1'b1, 1'b0);
        push(32'hB0000002, 1'b0);
        drv(1'b1, 32'hB0000002, 1'b0, 1'b0);
        drv(1'b0, 32'd0, 1'b0, 1'b1);
        wait_done(base);
        tick();
        chk("t4_idle_arm", {31'd0, indicator_arm}, 32'd0);
        chk("t4_idle_trg", {31'd0, indicator_trg}, 32'd0);
        chk("t4_sb_empty", sb.size(), 32'd0);
        // run and abort together: abort wins
        base = n_done;
        do_arm();
        drv(1'b0, 32'd0, 1'b1, 1'b1);
        chk("t4_no_trg", {31'd0, indicator_trg}, 32'd0);
        chk("t4_done_now", {31'd0, done}, 32'd1);
        wait_done(base);
        tick();

        // auto-rearm
        cfg(2'd0, 32'd2);
        cfg(2'd3, 32'd1);
        base = n_done;
        do_arm();
        push(32'hC0000001, 1'b0);
        drv(1'b1, 32'hC0000001, 1'b1, 1'b0);
        push(32'hC0000002, 1'b1);
        drv(1'b1, 32'hC0000002, 1'b0, 1'b0);
        wait_done(base);
        tick();
        chk("t5_rearmed", {31'd0, indicator_arm}, 32'd1);
        base = n_done;
        push(32'hC0000003, 1'b0);
        drv(1'b1, 32'hC0000003, 1'b1, 1'b0);
        push(32'hC0000004, 1'b1);
        drv(1'b1, 32'hC0000004, 1'b0, 1'b0);
        wait_done(base);
        tick();
        chk("t5_rearmed2", {31'd0, indicator_arm}, 32'd1);
        cfg(2'd3, 32'd0);
        base = n_done;
        drv(1'b0, 32'd0, 1'b0, 1'b1);
        wait_done(base);
        tick();
        chk("t5_idle", {31'd0, indicator_arm}, 32'd0);

        // tlast also on the trigger sample
        cfg(2'd3, 32'd2);
        base = n_done;
        do_arm();
        push(32'hD0000001, 1'b1);
        drv(1'b1, 32'hD0000001, 1'b1, 1'b0);
        push(32'hD0000002, 1'b1);
        drv(1'b1, 32'hD0000002, 1'b0, 1'b0);
        wait_done(base);
        tick();
        cfg(2'd3, 32'd0);
        chk("t5b_sb_empty", sb.size(), 32'd0);

`ifdef RUN_HOLDOFF_EN
        // run ignored until five pre-trigger samples have been taken
        cfg(2'd1, 32'd5);
        cfg(2'd0, 32'd2);
        base = n_done;
        do_arm();
        for (int k = 0; k < 3; k++) begin
            push(32'hE0000000 + k, 1'b0);
            drv(1'b1, 32'hE0000000 + k, 1'b0, 1'b0);
        end
        drv(1'b0, 32'd0, 1'b1, 1'b0);
        chk("t6_holdoff", {31'd0, indicator_trg}, 32'd0);
        for (int k = 3; k < 5; k++) begin
            push(32'hE0000000 + k, 1'b0);
            drv(1'b1, 32'hE0000000 + k, 1'b0, 1'b0);
        end
        push(32'hE0000005, 1'b0);
        drv(1'b1, 32'hE0000005, 1'b1, 1'b0);
        chk("t6_run_ok", {31'd0, indicator_trg}, 32'd1);
        push(32'hE0000006, 1'b1);
        drv(1'b1, 32'hE0000006, 1'b0, 1'b0);
        wait_done(base);
        tick();
        cfg(2'd1, 32'd0);
`endif

        // asynchronous reset in the middle of TRIG
        cfg(2'd0, 32'd100);
        sif.mwr_tready = 1'b0;
        do_arm();
        drv(1'b1, 32'hF0000001, 1'b1, 1'b0);
        chk("t6_in_trg", {31'd0, indicator_trg}, 32'd1);
        chk("t6_pending", {31'd0, sif.mwr_tvalid}, 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_tvalid",  {31'd0, sif.mwr_tvalid}, 32'd0);
        chk("arst_tdata",   sif.mwr_tdata, 32'd0);
        chk("arst_ind_trg", {31'd0, indicator_trg}, 32'd0);
        chk("arst_ind_arm", {31'd0, indicator_arm}, 32'd0);
        chk("arst_done",    {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sif.mwr_tready = 1'b1;
        tick();
        chk("arst_idle", {31'd0, indicator_arm | indicator_trg}, 32'd0);

        chk("final_sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
